// File: rtl/tlb_op_sequencer_pkg.sv
// Shared TLB types: the stored entry layout, the CP0 TLB opcode and the
// sequencer state encoding.
package tlb_op_sequencer_pkg;

    localparam int VPN2_W = 19;
    localparam int ASID_W = 8;
    localparam int PFN_W  = 20;

    // One joint TLB entry: a VPN2/ASID tag pair mapping an even/odd page pair.
    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [PFN_W-1:0]  pfn0;
        logic [2:0]        c0;
        logic              d0;
        logic              v0;
        logic [PFN_W-1:0]  pfn1;
        logic [2:0]        c1;
        logic              d1;
        logic              v1;
    } TLBEntry;

    typedef enum logic [1:0] {
        TLBR  = 2'd0,
        TLBWI = 2'd1,
        TLBWR = 2'd2,
        TLBP  = 2'd3
    } TLBOp;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_PROBE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/tlb_op_sequencer.sv
// Sequences TLBR/TLBWI/TLBWR/TLBP onto a time-multiplexed slow TLB whose
// ports are only ready while the addressed entry group is current.
//
// Handshake: a request is accepted on a cycle where req_valid && req_ready;
// req_ready is high only in IDLE, so at most one op is in flight. Request
// inputs are don't-care after the accepting edge. done is a one-cycle pulse
// in the first IDLE cycle after the op, and a new request may be accepted in
// that same cycle.
module tlb_op_sequencer
    import tlb_op_sequencer_pkg::*;
#(
    parameter int ENTRIES    = 64,
    parameter int GROUP_SIZE = 4,
    localparam int GROUPS    = ENTRIES / GROUP_SIZE,
    localparam int IW        = $clog2(ENTRIES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  TLBOp              req_op,
    output logic              req_ready,
    input  logic [IW-1:0]     req_index,
    input  logic [IW-1:0]     req_random,
    input  TLBEntry           req_entry,
    input  logic [VPN2_W-1:0] req_vpn2,
    input  logic [ASID_W-1:0] req_asid,
    output logic              done,
    output TLBEntry           resp_entry,
    output logic [IW-1:0]     resp_index,
    output logic              resp_miss,
    output logic [IW-1:0]     tlb_r_index,
    input  logic              tlb_r_ready,
    input  TLBEntry           tlb_r_resp,
    output logic              tlb_w_valid,
    output logic [IW-1:0]     tlb_w_index,
    output TLBEntry           tlb_w_data,
    input  logic              tlb_w_ready,
    output logic [VPN2_W-1:0] tlb_p_ivpn2,
    output logic [ASID_W-1:0] tlb_p_iasid,
    input  logic              tlb_p_ready,
    input  logic [IW-1:0]     tlb_p_index,
    output seq_state_e        fsm_state
);

    localparam int CW = $clog2(GROUPS) + 1;

    seq_state_e        state;
    seq_state_e        state_next;

    logic [IW-1:0]     idx_q;
    TLBEntry           entry_q;
    logic [VPN2_W-1:0] vpn2_q;
    logic [ASID_W-1:0] asid_q;
    logic [CW-1:0]     scan_cnt;
    logic              hit_q;
    logic [IW-1:0]     hit_idx_q;

    logic              accept;
    logic              scan_last;
    logic              done_set;
    logic              read_load;
    logic              probe_finish;

    assign scan_last = (scan_cnt == CW'(GROUPS - 1));

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: dispatch on opcode, leave when the group is current or the
    // probe has seen every group once.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (req_op)
                        TLBR:    state_next = ST_READ;
                        TLBWI,
                        TLBWR:   state_next = ST_WRITE;
                        TLBP:    state_next = ST_PROBE;
                        default: state_next = ST_IDLE;
                    endcase
                end
            end
            ST_READ:  if (tlb_r_ready) state_next = ST_IDLE;
            ST_WRITE: if (tlb_w_ready) state_next = ST_IDLE;
            ST_PROBE: if (scan_last)   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs and strobes for the datapath.
    always_comb begin
        req_ready    = (state == ST_IDLE);
        tlb_w_valid  = (state == ST_WRITE);
        accept       = req_valid && (state == ST_IDLE);
        read_load    = (state == ST_READ) && tlb_r_ready;
        probe_finish = (state == ST_PROBE) && scan_last;
        done_set     = read_load
                     || ((state == ST_WRITE) && tlb_w_ready)
                     || probe_finish;
    end

    // Request latches, probe scan bookkeeping and registered responses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q      <= '0;
            entry_q    <= '0;
            vpn2_q     <= '0;
            asid_q     <= '0;
            scan_cnt   <= '0;
            hit_q      <= 1'b0;
            hit_idx_q  <= '0;
            done       <= 1'b0;
            resp_entry <= '0;
            resp_index <= '0;
            resp_miss  <= 1'b0;
        end else begin
            done <= done_set;
            if (accept) begin
                idx_q     <= (req_op == TLBWR) ? req_random : req_index;
                entry_q   <= req_entry;
                vpn2_q    <= req_vpn2;
                asid_q    <= req_asid;
                scan_cnt  <= '0;
                hit_q     <= 1'b0;
                hit_idx_q <= '0;
            end else if (state == ST_PROBE) begin
                scan_cnt <= scan_cnt + 1'b1;
                // Only the first matching group counts; a multiple match is
                // a software error and is deliberately not flagged.
                if (tlb_p_ready && !hit_q) begin
                    hit_q     <= 1'b1;
                    hit_idx_q <= tlb_p_index;
                end
            end
            if (read_load) begin
                resp_entry <= tlb_r_resp;
            end
            // A hit in the final scan cycle still counts.
            if (probe_finish) begin
                resp_miss  <= !(hit_q || tlb_p_ready);
                resp_index <= hit_q ? hit_idx_q
                            : (tlb_p_ready ? tlb_p_index : '0);
            end
        end
    end

    assign tlb_r_index = idx_q;
    assign tlb_w_index = idx_q;
    assign tlb_w_data  = entry_q;
    assign tlb_p_ivpn2 = vpn2_q;
    assign tlb_p_iasid = asid_q;
    assign fsm_state   = state;

endmodule
